// File: rtl/multiplier_controller_taint1b.sv
// multiplier_controller_taint1b
//
// Control FSM for a sequential shift-add multiplier with 1-bit taint tracking.
// Walks the datapath through LOAD, then WIDTH ADD/SHIFT pairs, then a single
// DONE cycle. Each strobe carries a companion taint bit derived from a sticky
// control taint (ctl_t), which absorbs the taint of any start that launches
// an operation.
//
// Optional feature macro: MULT_CTRL_TAINT_RELEASE_EN
//   defined   - ctl_t is cleared on DONE -> IDLE, so each operation is
//               tainted independently
//   undefined - ctl_t stays set until rst (conservative default)
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   start, start_t                 multiply request and its taint
//   multiplierReg, multiplierReg_t loaded multiplier register and its taint
//   mrld, mrld_t                   load multiplier register
//   mdld, mdld_t                   load multiplicand register
//   rsclear, rsclear_t             clear running sum
//   rsload, rsload_t               add multiplicand into running sum
//   rsshr, rsshr_t                 arithmetic shift running sum right by 1
//   busy, busy_t                   operation in progress (LOAD/ADD/SHIFT)
//   done, done_t                   one-cycle pulse, product valid

module multiplier_controller_taint1b #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             start_t,
    input  logic [WIDTH-1:0] multiplierReg,
    input  logic             multiplierReg_t,
    output logic             mrld,
    output logic             mrld_t,
    output logic             mdld,
    output logic             mdld_t,
    output logic             rsclear,
    output logic             rsclear_t,
    output logic             rsload,
    output logic             rsload_t,
    output logic             rsshr,
    output logic             rsshr_t,
    output logic             busy,
    output logic             busy_t,
    output logic             done,
    output logic             done_t
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        ADD,
        SHIFT,
        DONE
    } state_e;

    state_e           state;
    state_e           next_state;
    logic [CNT_W-1:0] cnt;
    logic             ctl_t;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Bit counter and sticky control taint. The taint of start is absorbed
    // only when start actually launches an operation; multiplierReg_t never
    // steers control flow, so it never reaches ctl_t.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= '0;
            ctl_t <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        ctl_t <= ctl_t | start_t;
                    end
                end
                LOAD: begin
                    cnt <= '0;
                end
                SHIFT: begin
                    if (cnt != CNT_LAST) begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DONE: begin
`ifdef MULT_CTRL_TAINT_RELEASE_EN
                    ctl_t <= 1'b0;
`endif
                end
                default: begin
                end
            endcase
        end
    end

    // Next-state logic; ADD always proceeds to SHIFT regardless of the
    // multiplier bit, which keeps the schedule data-independent.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    next_state = start ? LOAD : IDLE;
            LOAD:    next_state = ADD;
            ADD:     next_state = SHIFT;
            SHIFT:   next_state = (cnt == CNT_LAST) ? DONE : ADD;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Output logic. Every taint follows ctl_t, except rsload_t which also
    // picks up the multiplier taint while the multiplier bit drives rsload.
    always_comb begin
        mrld      = 1'b0;
        mdld      = 1'b0;
        rsclear   = 1'b0;
        rsload    = 1'b0;
        rsshr     = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        mrld_t    = ctl_t;
        mdld_t    = ctl_t;
        rsclear_t = ctl_t;
        rsload_t  = ctl_t;
        rsshr_t   = ctl_t;
        busy_t    = ctl_t;
        done_t    = ctl_t;
        case (state)
            LOAD: begin
                mrld    = 1'b1;
                mdld    = 1'b1;
                rsclear = 1'b1;
                busy    = 1'b1;
            end
            ADD: begin
                rsload   = multiplierReg[cnt];
                rsload_t = ctl_t | multiplierReg_t;
                busy     = 1'b1;
            end
            SHIFT: begin
                rsshr = 1'b1;
                busy  = 1'b1;
            end
            DONE: begin
                done = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: doc/multiplier_controller_taint1b.md
# multiplier_controller_taint1b

Control FSM for the sequential shift-add multiplier with 1-bit taint tracking. It sits directly upstream of the multiplier datapath and drives its load, clear, add and shift strobes, each with a companion taint bit. It reads back the loaded multiplier register and its taint, and exposes a start/busy/done handshake to the surrounding system.

## Interface
- WIDTH, 4, operand width; must match the datapath WIDTH; ≥2
- clk  in  1  clock; all state updates on posedge
- rst  in  1  synchronous, active-high reset
- start, start_t  in  1, 1  request a multiply; taint of start
- multiplierReg, multiplierReg_t  in  WIDTH, 1  datapath multiplier register; its taint
- mrld, mrld_t  out  1, 1  load multiplier register; taint
- mdld, mdld_t  out  1, 1  load multiplicand register; taint
- rsclear, rsclear_t  out  1, 1  clear running sum; taint
- rsload, rsload_t  out  1, 1  add multiplicand into running sum; taint
- rsshr, rsshr_t  out  1, 1  arithmetic shift running sum right by 1; taint
- busy, busy_t  out  1, 1  operation in progress (LOAD/ADD/SHIFT); taint
- done, done_t  out  1, 1  one-cycle pulse, product valid this cycle; taint

## Operation
- States: IDLE, LOAD, ADD, SHIFT, DONE. Internal bit counter cnt is $clog2(WIDTH) bits wide. A sticky state taint bit ctl_t is also kept.
- IDLE: all strobes 0. If start=1, go to LOAD, and ctl_t |= start_t. If start=0, stay in IDLE.
- LOAD: mrld=mdld=rsclear=1; cnt←0; then go to ADD.
- ADD: rsload = multiplierReg[cnt] (combinational); then go to SHIFT unconditionally.
- SHIFT: rsshr=1. If cnt==WIDTH-1, go to DONE; otherwise cnt←cnt+1 and go to ADD.
- DONE: done=1 for exactly one cycle; then go to IDLE.
- busy=1 in LOAD, ADD and SHIFT; 0 otherwise.
- Strobes are mutually exclusive except in LOAD. The datapath priority (clear > load > shift) is therefore never exercised.
- Taint rules:
  - Every output _t equals ctl_t.
  - Exception: rsload_t = ctl_t | multiplierReg_t in ADD, and ctl_t in all other states.
  - multiplierReg_t never alters control flow (ADD→SHIFT is unconditional), so it never sets ctl_t.
- start and start_t are ignored outside IDLE.
- Zero multiplier: no rsload pulse occurs, and the product is 0.

## Timing
- Reset: state=IDLE, cnt=0, ctl_t=0; every output and every _t is 0 in the cycle after rst is sampled high.
- rst has priority over all transitions, including mid-operation. The datapath contents are then don't-care until the next LOAD.
- start sampled high in IDLE at edge k:
  - LOAD occupies cycle k+1.
  - ADD/SHIFT pairs occupy cycles k+2 … k+2·WIDTH+1.
  - DONE occupies cycle k+2·WIDTH+2.
  - For WIDTH=4, done is high 10 cycles after the start edge.
- Product is valid on the datapath output from the DONE cycle until the next LOAD.
- start held high continuously: DONE→IDLE→LOAD. The back-to-back restart period is 2·WIDTH+3 cycles.
- multiplierReg must be stable from the end of LOAD through the last ADD. The datapath guarantees this because mrld is asserted only in LOAD.

## Configuration
- MULT_CTRL_TAINT_RELEASE_EN:
  - Defined: ctl_t is cleared on the DONE→IDLE transition, so each operation's taint is independent.
  - Undefined (default): ctl_t is sticky until rst. This is the conservative setting.

## Test plan
- WIDTH=4, multiplicand=3, multiplier=5, no taint, start pulse → done exactly 10 cycles after the start edge; product=15; all _t=0.
- multiplier=4'b1010 → rsload over the four ADD cycles reads 0,1,0,1; rsshr is high on exactly 4 cycles.
- 15×15 → product=225. start is held high through DONE → a second LOAD occurs in the cycle after the IDLE cycle.
- start_t=1 on the start pulse → all control _t=1 from LOAD onward. After DONE:
  - With the macro: all _t=0 in IDLE.
  - Without the macro: _t stays 1 until rst.
- multiplierReg_t=1, start_t=0 → rsload_t=1 only in ADD cycles; every other _t=0; done_t=0.
- rst asserted in the 2nd ADD cycle → next cycle: IDLE, all outputs 0. A fresh 2×3 run then gives 6 with the nominal 10-cycle latency.
